ro_puf_sequencer: RTL and testbench

//  Challenge/response controller for the 16-RO PUF array. On start it walks RESP_BITS
//  RO pairs. For each pair it drives select1/select2, pulses the RO counter reset, opens
//  a fixed enable window, lets the async counters settle, then samples the comparator
//  bit (puf_out of the RO array). Replaces manual VIO stepping; response word goes to VIO/ILA.

---
 rtl/ro_puf_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_ro_puf_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_sequencer.sv
// Challenge/response sequencer for a 16-RO PUF array.
// For each response bit it selects an RO pair, resets the counters, opens a fixed
// enable window, waits for the counters to settle and then samples the comparator bit.
// Optional feature: define PUF_MAJORITY_EN to measure each pair three times and store
// the 2-of-3 majority vote. With the macro undefined, each pair is measured once.
module ro_puf_sequencer #(
    parameter int unsigned RESP_BITS     = 8,
    parameter int unsigned SEL_W         = 4,
    parameter int unsigned RST_CYCLES    = 4,
    parameter int unsigned WINDOW        = 4096,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SEL_W-1:0]     challenge,
    input  logic                 puf_in,
    output logic                 ro_enable,
    output logic                 ro_reset,
    output logic [SEL_W-1:0]     select1,
    output logic [SEL_W-1:0]     select2,
    output logic                 busy,
    output logic [3:0]           bit_index,
    output logic [RESP_BITS-1:0] response,
    output logic                 response_valid
);

    // Phase counter loads: counts down to zero, so each dwell loads (cycles - 1).
    localparam logic [15:0] RstLoad    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] CntLoad    = 16'(WINDOW - 1);
    localparam logic [15:0] SettleLoad = 16'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  LastBit    = 4'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StCnt,
        StSettle,
        StSample,
        StDone
    } state_e;

    state_e           state_q;
    logic [SEL_W-1:0] chal_q;
    logic [15:0]      phase_q;
    logic             sync1_q;
    logic             sync2_q;

    logic [4:0]       next_offset;
    logic [SEL_W-1:0] next_sel;
    logic             last_meas;
    logic             bit_val;

`ifdef PUF_MAJORITY_EN
    logic [1:0] rep_q;
    logic [1:0] votes_q;
`endif

    // Two-flop synchroniser for the asynchronous comparator output.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= puf_in;
            sync2_q <= sync1_q;
        end
    end

    // Pair offset for the next bit (2k wraps modulo 2^SEL_W) and the value to store.
    always_comb begin
        next_offset = {bit_index + 4'd1, 1'b0};
        next_sel    = chal_q + SEL_W'(next_offset);
`ifdef PUF_MAJORITY_EN
        last_meas   = (rep_q == 2'd2);
        bit_val     = ((votes_q + {1'b0, sync2_q}) >= 2'd2);
`else
        last_meas   = 1'b1;
        bit_val     = sync2_q;
`endif
    end

    // Measurement FSM; all outputs are registered and updated on state entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            chal_q         <= '0;
            phase_q        <= '0;
            ro_enable      <= 1'b0;
            ro_reset       <= 1'b0;
            select1        <= '0;
            select2        <= '0;
            busy           <= 1'b0;
            bit_index      <= '0;
            response       <= '0;
            response_valid <= 1'b0;
`ifdef PUF_MAJORITY_EN
            rep_q          <= '0;
            votes_q        <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        chal_q         <= challenge;
                        bit_index      <= '0;
                        response       <= '0;
                        response_valid <= 1'b0;
                        busy           <= 1'b1;
                        select1        <= challenge;
                        select2        <= challenge + SEL_W'(1);
                        ro_reset       <= 1'b1;
                        ro_enable      <= 1'b0;
                        phase_q        <= RstLoad;
                        state_q        <= StRst;
`ifdef PUF_MAJORITY_EN
                        rep_q          <= '0;
                        votes_q        <= '0;
`endif
                    end
                end
                StRst: begin
                    if (phase_q == '0) begin
                        ro_reset  <= 1'b0;
                        ro_enable <= 1'b1;
                        phase_q   <= CntLoad;
                        state_q   <= StCnt;
                    end else begin
                        phase_q <= phase_q - 16'd1;
                    end
                end
                StCnt: begin
                    if (phase_q == '0) begin
                        ro_enable <= 1'b0;
                        phase_q   <= SettleLoad;
                        state_q   <= StSettle;
                    end else begin
                        phase_q <= phase_q - 16'd1;
                    end
                end
                StSettle: begin
                    if (phase_q == '0) begin
                        phase_q <= '0;
                        state_q <= StSample;
                    end else begin
                        phase_q <= phase_q - 16'd1;
                    end
                end
                StSample: begin
                    if (!last_meas) begin
                        // Repeat the same pair; selects are left untouched.
                        ro_reset <= 1'b1;
                        phase_q  <= RstLoad;
                        state_q  <= StRst;
`ifdef PUF_MAJORITY_EN
                        rep_q    <= rep_q + 2'd1;
                        votes_q  <= votes_q + {1'b0, sync2_q};
`endif
                    end else begin
                        for (int i = 0; i < int'(RESP_BITS); i++) begin
                            if (bit_index == 4'(i)) begin
                                response[i] <= bit_val;
                            end
                        end
                        if (bit_index == LastBit) begin
                            busy           <= 1'b0;
                            response_valid <= 1'b1;
                            state_q        <= StDone;
                        end else begin
                            bit_index <= bit_index + 4'd1;
                            select1   <= next_sel;
                            select2   <= next_sel + SEL_W'(1);
                            ro_reset  <= 1'b1;
                            phase_q   <= RstLoad;
                            state_q   <= StRst;
`ifdef PUF_MAJORITY_EN
                            rep_q     <= '0;
                            votes_q   <= '0;
`endif
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Self-checking bench for ro_puf_sequencer with shortened timing parameters.
// The RO array is modelled as a list of per-measurement comparator outcomes; the
// expected response is the (majority of the) outcomes assigned to each bit.
module tb_ro_puf_sequencer;

    localparam int RB  = 8;
    localparam int SW  = 4;
    localparam int RC  = 2;
    localparam int WIN = 16;
    localparam int SC  = 8;
    localparam int M   = RC + WIN + SC + 1;
`ifdef PUF_MAJORITY_EN
    localparam int REPS = 3;
`else
    localparam int REPS = 1;
`endif
    localparam int MB = REPS * M;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] challenge = '0;
    logic          puf_in;
    logic          ro_enable, ro_reset, busy, response_valid;
    logic [SW-1:0] select1, select2;
    logic [3:0]    bit_index;
    logic [RB-1:0] response;

    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc   = 0;
    bit  meas_bits [64];
    int  meas_cnt = 0;
    bit  force_en = 1'b0;
    bit  force_val = 1'b0;
    logic [SW-1:0] chal_model = '0;

    assign puf_in = force_en ? force_val : meas_bits[(meas_cnt > 0) ? meas_cnt - 1 : 0];

    ro_puf_sequencer #(
        .RESP_BITS(RB), .SEL_W(SW), .RST_CYCLES(RC), .WINDOW(WIN), .SETTLE_CYCLES(SC)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .challenge(challenge), .puf_in(puf_in),
        .ro_enable(ro_enable), .ro_reset(ro_reset), .select1(select1), .select2(select2),
        .busy(busy), .bit_index(bit_index), .response(response),
        .response_valid(response_valid)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Environment monitor: counts measurements, checks pair selects and pulse shapes.
    bit prev_en = 1'b0, prev_rst = 1'b0;
    int en_len = 0, rst_len = 0;
    always @(negedge clock) begin
        if (reset) begin
            prev_en = 1'b0; prev_rst = 1'b0; en_len = 0; rst_len = 0; meas_cnt = 0;
        end else begin
            if (!busy) meas_cnt = 0;
            if (ro_enable || ro_reset)
                check_eq("en_rst_exclusive", 32'(ro_enable & ro_reset), 32'd0);
            if (ro_enable && !prev_en) begin
                int k;
                k = meas_cnt / REPS;
                meas_cnt++;
                check_eq("select1", 32'(select1), 32'((int'(chal_model) + 2 * k) % 16));
                check_eq("select2", 32'(select2), 32'((int'(chal_model) + 2 * k + 1) % 16));
            end
            if (ro_enable) en_len++;
            if (ro_reset) rst_len++;
            if (!ro_enable && prev_en) begin
                check_eq("enable_width", 32'(en_len), 32'(WIN));
                en_len = 0;
            end
            if (!ro_reset && prev_rst) begin
                check_eq("reset_width", 32'(rst_len), 32'(RC));
                rst_len = 0;
            end
            prev_en = ro_enable;
            prev_rst = ro_reset;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    function automatic logic [RB-1:0] model_resp();
        logic [RB-1:0] r;
        for (int k = 0; k < RB; k++) begin
            int ones;
            ones = 0;
            for (int j = 0; j < REPS; j++) ones += int'(meas_bits[k * REPS + j]);
            r[k] = (2 * ones > REPS);
        end
        return r;
    endfunction

    task automatic rand_meas();
        for (int i = 0; i < 64; i++) meas_bits[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic do_start(input logic [SW-1:0] c);
        chal_model = c;
        challenge = c;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        challenge = SW'($urandom);
        cyc = 1;
        check_eq("accept_busy", 32'(busy), 32'd1);
        check_eq("accept_valid", 32'(response_valid), 32'd0);
        check_eq("accept_resp", 32'(response), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        logic busy_prev;
        busy_prev = busy;
        while (!response_valid && cyc < RB * MB + 50) begin
            busy_prev = busy;
            tick(1);
        end
        check_eq({tag, "_done_cycle"}, 32'(cyc), 32'(RB * MB + 1));
        check_eq({tag, "_busy_prev"}, 32'(busy_prev), 32'd1);
        check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {8'd0, ro_enable, ro_reset, select1, select2, busy, bit_index, response,
                       response_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        tick(3);
        reset = 1'b0;
        tick(1);
        check_all_zero("reset_state");

        // Nominal: outcome 1 for even bits, 0 for odd bits
        for (int k = 0; k < RB; k++)
            for (int j = 0; j < REPS; j++) meas_bits[k * REPS + j] = (k % 2 == 0);
        do_start(4'h0);
        wait_done("nominal");
        check_eq("nominal_resp", 32'(response), 32'h55);

        // Reset in the middle of the first enable window aborts everything
        rand_meas();
        do_start(4'h5);
        tick(RC + 5);
        check_eq("mid_cnt_enable", 32'(ro_enable), 32'd1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_all_zero("abort_zero");
        end
        reset = 1'b0;
        tick(2);
        check_all_zero("abort_idle");
        do_start(4'h5);
        wait_done("after_abort");
        check_eq("after_abort_resp", 32'(response), 32'(model_resp()));

        // Wrap of the pair offset past the top RO index
        rand_meas();
        do_start(4'hE);
        wait_done("wrap");
        check_eq("wrap_resp", 32'(response), 32'(model_resp()));
        check_eq("wrap_last_sel1", 32'(select1), 32'hC);
        check_eq("wrap_last_sel2", 32'(select2), 32'hD);

        // Start pulse inside the window of bit 3 must be ignored
        rand_meas();
        do_start(4'h3);
        tick(3 * MB + RC + 4);
        check_eq("bit3_in_cnt", 32'({ro_enable, bit_index}), 32'h13);
        start = 1'b1;
        challenge = 4'h9;
        tick(1);
        start = 1'b0;
        check_eq("busy_start_ignored", 32'(bit_index), 32'd3);
        wait_done("busy_start");
        check_eq("busy_start_resp", 32'(response), 32'(model_resp()));
        // Restart from DONE clears the response (checked inside do_start)
        rand_meas();
        do_start(SW'($urandom));
        wait_done("restart");
        check_eq("restart_resp", 32'(response), 32'(model_resp()));

        // Synchroniser latency: a toggle one cycle before SAMPLE is missed, two is caught
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 64; i++) meas_bits[i] = 1'b0;
            if (REPS == 3) meas_bits[0] = 1'b1;
            do_start(4'h1);
            tick(MB - 3 + t);
            force_val = 1'b1;
            force_en = 1'b1;
            tick(3 - t);
            force_en = 1'b0;
            wait_done("toggle");
            check_eq(t == 0 ? "toggle_early_bit0" : "toggle_late_bit0", 32'(response[0]),
                     32'(t == 0));
        end

`ifdef PUF_MAJORITY_EN
        // Majority vote: 1,0,1 -> 1 and 0,0,1 -> 0
        rand_meas();
        meas_bits[0] = 1'b1; meas_bits[1] = 1'b0; meas_bits[2] = 1'b1;
        meas_bits[3] = 1'b0; meas_bits[4] = 1'b0; meas_bits[5] = 1'b1;
        do_start(4'h7);
        wait_done("majority");
        check_eq("majority_bit0", 32'(response[0]), 32'd1);
        check_eq("majority_bit1", 32'(response[1]), 32'd0);
        check_eq("majority_resp", 32'(response), 32'(model_resp()));
`endif

        // Randomized challenges and outcomes
        for (int r = 0; r < 4; r++) begin
            rand_meas();
            do_start(SW'($urandom));
            wait_done("random");
            check_eq("random_resp", 32'(response), 32'(model_resp()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
